// File: rtl/multicycle_controller_if.sv
// Bus between the multicycle controller and its datapath/memory side.
// The controller is the slave; the datapath/bench drives the master side.
interface multicycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       Opcode;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             dmem_req;
    logic             IRWrite;
    logic             PCWrite;
    logic             ALUSrc;
    logic             MemtoReg;
    logic             RegWrite;
    logic             MemRead;
    logic             MemWrite;
    logic             Branch;
    logic             JalrSel;
    logic             jal_signal;
    logic             lui_signal;
    logic             auipc_signal;
    logic [1:0]       ALUOp;
    logic [2:0]       state;
    logic             halted;
    logic             error;
    logic [CNT_W-1:0] instret;

    modport master (
        output Opcode, imem_ready, dmem_ready,
        input  imem_req, dmem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
               MemRead, MemWrite, Branch, JalrSel, jal_signal, lui_signal,
               auipc_signal, ALUOp, state, halted, error, instret
    );

    modport slave (
        input  Opcode, imem_ready, dmem_ready,
        output imem_req, dmem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
               MemRead, MemWrite, Branch, JalrSel, jal_signal, lui_signal,
               auipc_signal, ALUOp, state, halted, error, instret
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32-style control FSM: FETCH/DECODE/EXEC/MEM/WB with memory wait
// timeout, HALT/ERR absorbing states and a retired-instruction counter.
module multicycle_controller #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int AUIPC_EN       = 1,
    parameter int CNT_W          = 32
) (
    input logic                    clk,
    input logic                    reset,
    multicycle_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NONE, C_R, C_I, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_HALT
    } cls_t;

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

    state_t           state_q;
    cls_t             cls_q;
    cls_t             cls_d;
    logic [WAIT_W-1:0] wait_q;
    logic [WAIT_W-1:0] wait_inc;
    logic             timeout_hit;
    logic [CNT_W-1:0] instret_q;

    logic       imem_req, dmem_req, ir_write, pc_write, alu_src, memto_reg;
    logic       reg_write, mem_read, mem_write, branch, jalr_sel;
    logic       jal_s, lui_s, auipc_s;
    logic [1:0] alu_op;

    function automatic cls_t decode(input logic [6:0] op);
        case (op)
            7'b0110011: return C_R;
            7'b0010011: return C_I;
            7'b0000011: return C_LW;
            7'b0100011: return C_SW;
            7'b1100011: return C_BR;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            7'b0110111: return C_LUI;
            7'b0010111: return (AUIPC_EN != 0) ? C_AUIPC : C_NONE;
            7'b1111111: return C_HALT;
            default:    return C_NONE;
        endcase
    endfunction

    assign cls_d       = decode(bus.Opcode);
    assign wait_inc    = wait_q + 1'b1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_inc == WAIT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NONE;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            instret_q <= instret_q + CNT_W'(pc_write);
            case (state_q)
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        wait_q  <= '0;
                        state_q <= S_DECODE;
                    end else begin
                        wait_q <= wait_inc;
                        if (timeout_hit) state_q <= S_ERR;
                    end
                end
                S_DECODE: begin
                    cls_q <= cls_d;
                    if (cls_d == C_HALT)      state_q <= S_HALT;
                    else if (cls_d == C_NONE) state_q <= S_ERR;
                    else                      state_q <= S_EXEC;
                end
                S_EXEC: begin
                    case (cls_q)
                        C_LW, C_SW: state_q <= S_MEM;
                        C_BR:       state_q <= S_FETCH;
                        default:    state_q <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        wait_q  <= '0;
                        state_q <= (cls_q == C_LW) ? S_WB : S_FETCH;
                    end else begin
                        wait_q <= wait_inc;
                        if (timeout_hit) state_q <= S_ERR;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                S_ERR:   state_q <= S_ERR;
                default: state_q <= S_ERR;
            endcase
        end
    end

    // Controls decode from the registered state/class; only IRWrite and the
    // SW-completion PCWrite look at a ready input. Reset forces everything low.
    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        alu_src   = 1'b0;
        memto_reg = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        jalr_sel  = 1'b0;
        jal_s     = 1'b0;
        lui_s     = 1'b0;
        auipc_s   = 1'b0;
        alu_op    = 2'b00;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_write = bus.imem_ready;
                end
                S_EXEC: begin
                    case (cls_q)
                        C_BR:        alu_op = 2'b01;
                        C_R, C_I:    alu_op = 2'b10;
                        C_JAL, C_JALR: alu_op = 2'b11;
                        default:     alu_op = 2'b00;
                    endcase
                    alu_src  = (cls_q inside {C_LW, C_SW, C_I, C_JAL, C_JALR, C_AUIPC});
                    branch   = (cls_q inside {C_BR, C_JAL, C_JALR});
                    jalr_sel = (cls_q == C_JALR);
                    pc_write = (cls_q == C_BR);
                end
                S_MEM: begin
                    dmem_req  = 1'b1;
                    mem_read  = (cls_q == C_LW);
                    mem_write = (cls_q == C_SW);
                    pc_write  = (cls_q == C_SW) && bus.dmem_ready;
                end
                S_WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    memto_reg = (cls_q == C_LW);
                    jal_s     = (cls_q inside {C_JAL, C_JALR});
                    lui_s     = (cls_q == C_LUI);
                    auipc_s   = (cls_q == C_AUIPC);
                end
                default: ;
            endcase
        end
    end

    assign bus.imem_req     = imem_req;
    assign bus.dmem_req     = dmem_req;
    assign bus.IRWrite      = ir_write;
    assign bus.PCWrite      = pc_write;
    assign bus.ALUSrc       = alu_src;
    assign bus.MemtoReg     = memto_reg;
    assign bus.RegWrite     = reg_write;
    assign bus.MemRead      = mem_read;
    assign bus.MemWrite     = mem_write;
    assign bus.Branch       = branch;
    assign bus.JalrSel      = jalr_sel;
    assign bus.jal_signal   = jal_s;
    assign bus.lui_signal   = lui_s;
    assign bus.auipc_signal = auipc_s;
    assign bus.ALUOp        = alu_op;
    assign bus.state        = state_q;
    assign bus.halted       = (state_q == S_HALT);
    assign bus.error        = (state_q == S_ERR);
    assign bus.instret      = instret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: default-parameter controller plus one with AUIPC disabled
// and a 4-bit retire counter, sharing clock and reset.
module tb_multicycle_controller;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_HALT  = 7'b1111111;

    multicycle_controller_if #(.CNT_W(32)) bus0 ();
    multicycle_controller_if #(.CNT_W(4))  bus1 ();

    multicycle_controller #(.TIMEOUT_CYCLES(16), .AUIPC_EN(1), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    multicycle_controller #(.TIMEOUT_CYCLES(16), .AUIPC_EN(0), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic rst_seq();
        reset = 1'b0;
        bus0.Opcode = '0; bus0.imem_ready = 1'b0; bus0.dmem_ready = 1'b0;
        bus1.Opcode = '0; bus1.imem_ready = 1'b0; bus1.dmem_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus0.Opcode = '0; bus0.imem_ready = 1'b0; bus0.dmem_ready = 1'b0;
        bus1.Opcode = '0; bus1.imem_ready = 1'b0; bus1.dmem_ready = 1'b0;
        #3;
        chk("rst_state",   bus0.state, 0);
        chk("rst_imemreq", bus0.imem_req, 0);
        chk("rst_instret", bus0.instret, 0);
        chk("rst_error",   bus0.error, 0);
        chk("rst_halted",  bus0.halted, 0);

        // add: F,D,E,WB with immediate imem_ready
        rst_seq();
        bus0.Opcode = OP_R; bus0.imem_ready = 1'b1; #1;
        chk("add_f_state", bus0.state, 0);
        chk("add_f_irw",   bus0.IRWrite, 1);
        chk("add_f_req",   bus0.imem_req, 1);
        tick(); bus0.imem_ready = 1'b0; #1;
        chk("add_d_state", bus0.state, 1);
        chk("add_d_irw",   bus0.IRWrite, 0);
        tick();
        chk("add_e_state", bus0.state, 2);
        chk("add_e_aluop", bus0.ALUOp, 2'b10);
        chk("add_e_alusrc", bus0.ALUSrc, 0);
        chk("add_e_regw",  bus0.RegWrite, 0);
        tick();
        chk("add_w_state", bus0.state, 4);
        chk("add_w_regw",  bus0.RegWrite, 1);
        chk("add_w_pcw",   bus0.PCWrite, 1);
        chk("add_w_instret", bus0.instret, 0);
        tick();
        chk("add_done_state", bus0.state, 0);
        chk("add_done_instret", bus0.instret, 1);
        chk("add_done_regw", bus0.RegWrite, 0);

        // lw with dmem_ready on the 4th MEM cycle
        rst_seq();
        bus0.Opcode = OP_LW; bus0.imem_ready = 1'b1;
        tick(); bus0.imem_ready = 1'b0;
        tick();
        chk("lw_e_alusrc", bus0.ALUSrc, 1);
        chk("lw_e_aluop",  bus0.ALUOp, 2'b00);
        tick();
        chk("lw_m1_state", bus0.state, 3);
        chk("lw_m1_memrd", bus0.MemRead, 1);
        chk("lw_m1_dreq",  bus0.dmem_req, 1);
        tick(); tick(); tick();
        bus0.dmem_ready = 1'b1; #1;
        chk("lw_m4_state", bus0.state, 3);
        chk("lw_m4_memrd", bus0.MemRead, 1);
        chk("lw_m4_pcw",   bus0.PCWrite, 0);
        tick(); bus0.dmem_ready = 1'b0; #1;
        chk("lw_w_state", bus0.state, 4);
        chk("lw_w_m2r",   bus0.MemtoReg, 1);
        chk("lw_w_regw",  bus0.RegWrite, 1);
        chk("lw_w_memrd", bus0.MemRead, 0);
        tick();
        chk("lw_instret", bus0.instret, 1);

        // beq retires from EXEC
        rst_seq();
        bus0.Opcode = OP_BR; bus0.imem_ready = 1'b1;
        tick(); bus0.imem_ready = 1'b0;
        tick();
        chk("br_e_state",  bus0.state, 2);
        chk("br_e_branch", bus0.Branch, 1);
        chk("br_e_aluop",  bus0.ALUOp, 2'b01);
        chk("br_e_pcw",    bus0.PCWrite, 1);
        tick();
        chk("br_next_state", bus0.state, 0);
        chk("br_instret",    bus0.instret, 1);

        // jal: EXEC branch/aluop 11, WB jal_signal
        rst_seq();
        bus0.Opcode = OP_JAL; bus0.imem_ready = 1'b1;
        tick(); bus0.imem_ready = 1'b0;
        tick();
        chk("jal_e_aluop",  bus0.ALUOp, 2'b11);
        chk("jal_e_branch", bus0.Branch, 1);
        chk("jal_e_jalr",   bus0.JalrSel, 0);
        tick();
        chk("jal_w_sig", bus0.jal_signal, 1);

        // auipc: legal on dut0, illegal on dut1
        rst_seq();
        bus0.Opcode = OP_AUIPC; bus0.imem_ready = 1'b1;
        bus1.Opcode = OP_AUIPC; bus1.imem_ready = 1'b1;
        tick(); bus0.imem_ready = 1'b0; bus1.imem_ready = 1'b0;
        tick();
        chk("auipc_e_alusrc", bus0.ALUSrc, 1);
        chk("auipc_e_aluop",  bus0.ALUOp, 2'b00);
        chk("auipc_off_state", bus1.state, 6);
        chk("auipc_off_error", bus1.error, 1);
        tick();
        chk("auipc_w_sig", bus0.auipc_signal, 1);
        chk("auipc_w_state", bus0.state, 4);

        // halt opcode
        rst_seq();
        bus0.Opcode = OP_HALT; bus0.imem_ready = 1'b1;
        tick(); bus0.imem_ready = 1'b0;
        tick();
        chk("halt_state",  bus0.state, 5);
        chk("halt_flag",   bus0.halted, 1);
        chk("halt_ireq",   bus0.imem_req, 0);
        tick(); tick();
        chk("halt_sticky", bus0.state, 5);

        // unrecognised opcode
        rst_seq();
        bus0.Opcode = 7'b0000000; bus0.imem_ready = 1'b1;
        tick(); bus0.imem_ready = 1'b0;
        tick();
        chk("illegal_state", bus0.state, 6);
        chk("illegal_error", bus0.error, 1);

        // fetch timeout after 16 waiting cycles
        rst_seq();
        repeat (15) tick();
        chk("to_c16_state", bus0.state, 0);
        tick();
        chk("to_err_state", bus0.state, 6);
        chk("to_err_flag",  bus0.error, 1);
        chk("to_err_ireq",  bus0.imem_req, 0);
        bus0.imem_ready = 1'b1;
        repeat (3) tick();
        chk("to_err_sticky", bus0.error, 1);
        chk("to_err_irw",    bus0.IRWrite, 0);

        // ready in the 16th waiting cycle wins over timeout
        rst_seq();
        repeat (15) tick();
        bus0.Opcode = OP_R; bus0.imem_ready = 1'b1; #1;
        chk("to_ready_irw", bus0.IRWrite, 1);
        tick(); bus0.imem_ready = 1'b0;
        chk("to_ready_state", bus0.state, 1);

        // sw aborted by asynchronous reset during MEM wait
        rst_seq();
        bus0.Opcode = OP_SW; bus0.imem_ready = 1'b1;
        tick(); bus0.imem_ready = 1'b0;
        tick(); tick();
        chk("sw_m_state", bus0.state, 3);
        chk("sw_m_memwr", bus0.MemWrite, 1);
        chk("sw_m_memrd", bus0.MemRead, 0);
        tick();
        #1 reset = 1'b0;
        #1;
        chk("sw_arst_state",   bus0.state, 0);
        chk("sw_arst_memwr",   bus0.MemWrite, 0);
        chk("sw_arst_dreq",    bus0.dmem_req, 0);
        chk("sw_arst_instret", bus0.instret, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("sw_rel_state", bus0.state, 0);
        chk("sw_rel_ireq",  bus0.imem_req, 1);

        // 17 retires on a 4-bit counter wrap to 1
        rst_seq();
        bus1.Opcode = OP_R; bus1.imem_ready = 1'b1;
        repeat (68) tick();
        chk("wrap_instret", bus1.instret, 1);
        chk("wrap_state",   bus1.state, 0);
        bus1.imem_ready = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
